// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS-style CPU: sequences fetch/decode/execute/memory/write-back
// and drives every datapath select and enable, plus alu_op one cycle ahead for the registered ALU control.
module multicycle_controller (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] i_opcode,
   input  logic       i_zero,
   input  logic       i_mem_ready,
   output logic       o_mem_read,
   output logic       o_mem_write,
   output logic       o_iord,
   output logic       o_ir_write,
   output logic       o_pc_en,
   output logic [1:0] o_pc_src,
   output logic       o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic [1:0] o_alu_op,
   output logic       o_reg_dst,
   output logic       o_mem_to_reg,
   output logic       o_reg_write,
   output logic       o_illegal,
   output logic [3:0] o_state
);

   typedef enum logic [3:0] {
      S_INIT     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_WB_R     = 4'd4,
      S_EXEC_I   = 4'd5,
      S_WB_I     = 4'd6,
      S_MEM_ADDR = 4'd7,
      S_MEM_RD   = 4'd8,
      S_WB_MEM   = 4'd9,
      S_MEM_WR   = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12,
      S_HALT     = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b000001;
   localparam logic [5:0] OP_SLTI  = 6'b000010;
   localparam logic [5:0] OP_LW    = 6'b000011;
   localparam logic [5:0] OP_SW    = 6'b000100;
   localparam logic [5:0] OP_BEQ   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000110;

   localparam logic [1:0] ALU_RTYPE = 2'b00;
   localparam logic [1:0] ALU_ADD   = 2'b01;
   localparam logic [1:0] ALU_SUB   = 2'b10;
   localparam logic [1:0] ALU_SLT   = 2'b11;

   state_t r_state;
   state_t w_next_state;

   // Unknown opcodes land in HALT, which only reset can leave.
   function automatic state_t decode_target(input logic [5:0] op);
      case (op)
         OP_RTYPE:         decode_target = S_EXEC_R;
         OP_ADDI, OP_SLTI: decode_target = S_EXEC_I;
         OP_LW, OP_SW:     decode_target = S_MEM_ADDR;
         OP_BEQ:           decode_target = S_BRANCH;
         OP_J:             decode_target = S_JUMP;
         default:          decode_target = S_HALT;
      endcase
   endfunction

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = S_INIT;
      case (r_state)
         S_INIT:     w_next_state = S_FETCH;
         S_FETCH:    w_next_state = i_mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:   w_next_state = decode_target(i_opcode);
         S_EXEC_R:   w_next_state = S_WB_R;
         S_WB_R:     w_next_state = S_FETCH;
         S_EXEC_I:   w_next_state = S_WB_I;
         S_WB_I:     w_next_state = S_FETCH;
         S_MEM_ADDR: begin
            if (i_opcode == OP_LW) begin
               w_next_state = S_MEM_RD;
            end else if (i_opcode == OP_SW) begin
               w_next_state = S_MEM_WR;
            end else begin
               w_next_state = S_HALT;
            end
         end
         S_MEM_RD:   w_next_state = i_mem_ready ? S_WB_MEM : S_MEM_RD;
         S_WB_MEM:   w_next_state = S_FETCH;
         S_MEM_WR:   w_next_state = i_mem_ready ? S_FETCH : S_MEM_WR;
         S_BRANCH:   w_next_state = S_FETCH;
         S_JUMP:     w_next_state = S_FETCH;
         S_HALT:     w_next_state = S_HALT;
         default:    w_next_state = S_INIT;
      endcase
   end

   // Datapath controls decoded from the current state; ir_write/pc_en also follow mem_ready/zero
   always_comb begin
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      o_iord       = 1'b0;
      o_ir_write   = 1'b0;
      o_pc_en      = 1'b0;
      o_pc_src     = 2'b00;
      o_alu_src_a  = 1'b0;
      o_alu_src_b  = 2'b00;
      o_reg_dst    = 1'b0;
      o_mem_to_reg = 1'b0;
      o_reg_write  = 1'b0;
      o_illegal    = 1'b0;
      case (r_state)
         S_FETCH: begin
            o_mem_read  = 1'b1;
            o_alu_src_b = 2'b01;
            o_ir_write  = i_mem_ready;
            o_pc_en     = i_mem_ready;
         end
         S_DECODE: begin
            o_alu_src_b = 2'b11;
         end
         S_EXEC_R: begin
            o_alu_src_a = 1'b1;
         end
         S_WB_R: begin
            o_reg_dst   = 1'b1;
            o_reg_write = 1'b1;
         end
         S_EXEC_I, S_MEM_ADDR: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = 2'b10;
         end
         S_WB_I: begin
            o_reg_write = 1'b1;
         end
         S_MEM_RD: begin
            o_mem_read = 1'b1;
            o_iord     = 1'b1;
         end
         S_WB_MEM: begin
            o_mem_to_reg = 1'b1;
            o_reg_write  = 1'b1;
         end
         S_MEM_WR: begin
            o_mem_write = 1'b1;
            o_iord      = 1'b1;
         end
         S_BRANCH: begin
            o_alu_src_a = 1'b1;
            o_pc_src    = 2'b01;
            o_pc_en     = i_zero;
         end
         S_JUMP: begin
            o_pc_src = 2'b10;
            o_pc_en  = 1'b1;
         end
         S_HALT: begin
            o_illegal = 1'b1;
         end
         default: begin
            o_illegal = 1'b0;
         end
      endcase
   end

   // alu_op keys off the next state because the ALU control unit adds a register stage
   always_comb begin
      o_alu_op = ALU_ADD;
      case (w_next_state)
         S_EXEC_R: o_alu_op = ALU_RTYPE;
         S_EXEC_I: o_alu_op = (i_opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
         S_BRANCH: o_alu_op = ALU_SUB;
         default:  o_alu_op = ALU_ADD;
      endcase
   end

   assign o_state = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is expanded into its expected
// state walk, and every cycle's outputs are checked against values derived from that walk.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       o_mem_read, o_mem_write, o_iord, o_ir_write, o_pc_en;
   logic [1:0] o_pc_src, o_alu_src_b, o_alu_op;
   logic       o_alu_src_a, o_reg_dst, o_mem_to_reg, o_reg_write, o_illegal;
   logic [3:0] o_state;

   multicycle_controller dut (
      .clk(clk), .rst_n(rst_n), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(mem_ready),
      .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_iord(o_iord),
      .o_ir_write(o_ir_write), .o_pc_en(o_pc_en), .o_pc_src(o_pc_src),
      .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_alu_op(o_alu_op),
      .o_reg_dst(o_reg_dst), .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write),
      .o_illegal(o_illegal), .o_state(o_state)
   );

   always #5 clk = ~clk;

   localparam int ST_INIT = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC_R = 3, ST_WB_R = 4,
                  ST_EXEC_I = 5, ST_WB_I = 6, ST_MEM_ADDR = 7, ST_MEM_RD = 8, ST_WB_MEM = 9,
                  ST_MEM_WR = 10, ST_BRANCH = 11, ST_JUMP = 12, ST_HALT = 15;
   localparam logic [5:0] OP_R = 6'd0, OP_ADDI = 6'd1, OP_SLTI = 6'd2, OP_LW = 6'd3,
                          OP_SW = 6'd4, OP_BEQ = 6'd5, OP_J = 6'd6;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_en;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       illegal;
      logic [3:0] state;
   } outs_t;

   outs_t act_o;
   outs_t exp_o;
   bit    exp_valid = 1'b0;
   assign act_o = {o_mem_read, o_mem_write, o_iord, o_ir_write, o_pc_en, o_pc_src, o_alu_src_a,
                   o_alu_src_b, o_alu_op, o_reg_dst, o_mem_to_reg, o_reg_write, o_illegal, o_state};

   int n_checks = 0;
   int n_fail = 0;
   logic [1:0] cap_dec_aluop = 2'b00;
   logic       cap_br_pcen = 1'b0;
   logic [1:0] cap_br_pcsrc = 2'b00;
   int halt_ill_cnt = 0, halt_en_cnt = 0, mrd_cnt = 0;

   string       lit_name [64];
   logic [31:0] lit_act [64];
   logic [31:0] lit_exp [64];
   int lit_wr = 0;
   int lit_rd = 0;

   function automatic bit rbit();
      return ($urandom & 32'd1) != 32'd0;
   endfunction

   // Expected outputs for one cycle, from the current step of the walk and the step after it
   function automatic outs_t model_outs(input int s, input bit rdy, input bit z, input int ns,
                                        input logic [5:0] op);
      outs_t o;
      o = '0;
      o.state = 4'(s);
      case (s)
         ST_FETCH:    begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_en = rdy; end
         ST_DECODE:   o.alu_src_b = 2'b11;
         ST_EXEC_R:   o.alu_src_a = 1'b1;
         ST_WB_R:     begin o.reg_dst = 1'b1; o.reg_write = 1'b1; end
         ST_EXEC_I:   begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
         ST_WB_I:     o.reg_write = 1'b1;
         ST_MEM_ADDR: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
         ST_MEM_RD:   begin o.mem_read = 1'b1; o.iord = 1'b1; end
         ST_WB_MEM:   begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
         ST_MEM_WR:   begin o.mem_write = 1'b1; o.iord = 1'b1; end
         ST_BRANCH:   begin o.alu_src_a = 1'b1; o.pc_src = 2'b01; o.pc_en = z; end
         ST_JUMP:     begin o.pc_src = 2'b10; o.pc_en = 1'b1; end
         ST_HALT:     o.illegal = 1'b1;
         default:     o.illegal = 1'b0;
      endcase
      if (ns == ST_EXEC_R) o.alu_op = 2'b00;
      else if (ns == ST_EXEC_I) o.alu_op = (op == OP_SLTI) ? 2'b11 : 2'b01;
      else if (ns == ST_BRANCH) o.alu_op = 2'b10;
      else o.alu_op = 2'b01;
      return o;
   endfunction

   // Compare process: per-cycle model check plus queued literal checks
   always @(negedge clk) begin
      if (exp_valid) begin
         n_checks++;
         if (act_o !== exp_o) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t: got %h (state %0d) expected %h (state %0d)",
                     $time, act_o, act_o.state, exp_o, exp_o.state);
         end
         if (exp_o.state == 4'd2) cap_dec_aluop = o_alu_op;
         if (exp_o.state == 4'd11) begin cap_br_pcen = o_pc_en; cap_br_pcsrc = o_pc_src; end
         if (exp_o.state == 4'd8 && o_mem_read && o_iord) mrd_cnt++;
         if (exp_o.state == 4'd15) begin
            if (o_illegal) halt_ill_cnt++;
            if (o_mem_read || o_mem_write || o_ir_write || o_pc_en || o_reg_write) halt_en_cnt++;
         end
      end
      while (lit_rd < lit_wr) begin
         n_checks++;
         if (lit_act[lit_rd] !== lit_exp[lit_rd]) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
         end
         lit_rd++;
      end
   end

   task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
      if (lit_wr < 64) begin
         lit_name[lit_wr] = nm;
         lit_act[lit_wr] = a;
         lit_exp[lit_wr] = e;
         lit_wr++;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      outs_t r;
      r = '0;
      r.alu_op = 2'b01;
      @(posedge clk); #1;
      rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'($urandom); zero = rbit();
      exp_o = r; exp_valid = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1; mem_ready = rbit();
   endtask

   // Expand one instruction into its state walk and drive it; abort_at>=0 resets mid-walk
   task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input bit z,
                            input int halt_len, input int abort_at, output int ncyc);
      int st_q[$];
      int n, s, ns;
      bit rdy;
      for (int k = 0; k <= wf; k++) st_q.push_back(ST_FETCH);
      st_q.push_back(ST_DECODE);
      case (op)
         OP_R:             begin st_q.push_back(ST_EXEC_R); st_q.push_back(ST_WB_R); end
         OP_ADDI, OP_SLTI: begin st_q.push_back(ST_EXEC_I); st_q.push_back(ST_WB_I); end
         OP_LW: begin
            st_q.push_back(ST_MEM_ADDR);
            for (int k = 0; k <= wm; k++) st_q.push_back(ST_MEM_RD);
            st_q.push_back(ST_WB_MEM);
         end
         OP_SW: begin
            st_q.push_back(ST_MEM_ADDR);
            for (int k = 0; k <= wm; k++) st_q.push_back(ST_MEM_WR);
         end
         OP_BEQ:  st_q.push_back(ST_BRANCH);
         OP_J:    st_q.push_back(ST_JUMP);
         default: for (int k = 0; k < halt_len; k++) st_q.push_back(ST_HALT);
      endcase
      n = st_q.size();
      ncyc = n;
      for (int i = 0; i < n; i++) begin
         if (i == abort_at) begin
            do_reset();
            return;
         end
         @(posedge clk); #1;
         s = st_q[i];
         ns = (i + 1 < n) ? st_q[i+1] : ((s == ST_HALT) ? ST_HALT : ST_FETCH);
         if (s == ST_FETCH || s == ST_MEM_RD || s == ST_MEM_WR) rdy = (ns != s);
         else rdy = rbit();
         opcode = (s == ST_FETCH) ? 6'($urandom) : op;
         zero = (s == ST_BRANCH) ? z : rbit();
         mem_ready = rdy;
         exp_o = model_outs(s, rdy, zero, ns, op);
      end
      if (st_q[n-1] == ST_HALT) do_reset();
   endtask

   initial begin
      int nc, h0, e0, m0, r, ab;
      logic [5:0] op;
      do_reset();

      run_instr(OP_R, 0, 0, 1'b0, 0, -1, nc); settle();
      lit("cpi_rtype", 32'(nc), 32'd4);
      lit("dec_aluop_rtype", 32'(cap_dec_aluop), 32'd0);
      run_instr(OP_ADDI, 0, 0, 1'b0, 0, -1, nc); settle();
      lit("cpi_addi", 32'(nc), 32'd4);
      lit("dec_aluop_addi", 32'(cap_dec_aluop), 32'd1);
      run_instr(OP_SLTI, 0, 0, 1'b0, 0, -1, nc); settle();
      lit("dec_aluop_slti", 32'(cap_dec_aluop), 32'd3);
      m0 = mrd_cnt;
      run_instr(OP_LW, 0, 2, 1'b0, 0, -1, nc); settle();
      lit("cpi_lw_wait2", 32'(nc), 32'd7);
      lit("lw_read_hold", 32'(mrd_cnt - m0), 32'd3);
      run_instr(OP_LW, 0, 0, 1'b0, 0, -1, nc); settle();
      lit("cpi_lw", 32'(nc), 32'd5);
      run_instr(OP_SW, 0, 0, 1'b0, 0, -1, nc); settle();
      lit("cpi_sw", 32'(nc), 32'd4);
      run_instr(OP_BEQ, 0, 0, 1'b1, 0, -1, nc); settle();
      lit("cpi_beq", 32'(nc), 32'd3);
      lit("beq_taken_pc_en", 32'(cap_br_pcen), 32'd1);
      lit("beq_pc_src", 32'(cap_br_pcsrc), 32'd1);
      lit("dec_aluop_beq", 32'(cap_dec_aluop), 32'd2);
      run_instr(OP_BEQ, 1, 0, 1'b0, 0, -1, nc); settle();
      lit("beq_not_taken_pc_en", 32'(cap_br_pcen), 32'd0);
      run_instr(OP_J, 0, 0, 1'b0, 0, -1, nc); settle();
      lit("cpi_j", 32'(nc), 32'd3);
      h0 = halt_ill_cnt; e0 = halt_en_cnt;
      run_instr(6'h3f, 0, 0, 1'b0, 20, -1, nc);
      lit("halt_illegal_cycles", 32'(halt_ill_cnt - h0), 32'd20);
      lit("halt_enables", 32'(halt_en_cnt - e0), 32'd0);
      lit("illegal_after_reset", 32'(o_illegal), 32'd0);
      lit("state_after_reset", 32'(o_state), 32'd0);

      for (int t = 0; t < 300; t++) begin
         r = int'($urandom_range(0, 19));
         op = (r == 0) ? 6'($urandom_range(7, 63)) : 6'(r % 7);
         ab = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 7)) : -1;
         run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rbit(),
                   int'($urandom_range(3, 6)), ab, nc);
      end

      settle();
      exp_valid = 1'b0;
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
